// File: rtl/edubos5_rf_mp.sv
// eduBOS5 multi-port register file: NWR synchronous write ports, NRD combinational read ports,
// hardware clear sequencer, optional hardwired x0, write->read bypass and write-conflict flag.
module edubos5_rf_mp #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned NRD        = 2,
  parameter int unsigned NWR        = 1,
  parameter bit          ZERO_X0    = 1'b1,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          CLR_ON_RST = 1'b1,
  localparam int unsigned AW        = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                clr_req,
  output logic                clr_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_dat,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_dat,
  output logic                wr_conflict
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic            clr_busy_d;
  logic            wr_conflict_d;
  logic            conflict_c;
  logic [NWR-1:0]  wr_ok;

  logic [XLEN-1:0] rf [NREGS];
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
    assign wa[p] = wr_addr[p*AW +: AW];
    assign wd[p] = wr_dat[p*XLEN +: XLEN];
  end

  // A port write takes effect only in IDLE and only to a real, writable register
  always_comb begin
    wr_ok = '0;
    for (int p = 0; p < NWR; p++) begin
      wr_ok[p] = wr_en[p] && (state_q == ST_IDLE) && in_range(wa[p])
                 && !(ZERO_X0 && (wa[p] == '0));
    end
  end

  // Two or more effective writes to the same register this cycle
  always_comb begin
    conflict_c = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_ok[p] && wr_ok[q] && (wa[p] == wa[q])) conflict_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    clr_busy_d    = clr_busy;
    wr_conflict_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_conflict_d = conflict_c;
        if (clr_req) begin
          state_d    = ST_CLEAR;
          clr_idx_d  = '0;
          clr_busy_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(NREGS - 1)) begin
          state_d    = ST_IDLE;
          clr_idx_d  = '0;
          clr_busy_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= CLR_ON_RST ? ST_CLEAR : ST_IDLE;
      clr_idx_q   <= '0;
      clr_busy    <= CLR_ON_RST;
      wr_conflict <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      clr_busy    <= clr_busy_d;
      wr_conflict <= wr_conflict_d;
    end
  end

  // Storage has no reset; later ports override earlier ones on an address clash
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      rf[clr_idx_q] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p]) rf[wa[p]] <= wd[p];
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;

    assign ra = rd_addr[r*AW +: AW];

    // Reads are zero while clearing, for x0 and for out-of-range addresses
    always_comb begin
      val = '0;
      if ((state_q == ST_IDLE) && in_range(ra) && !(ZERO_X0 && (ra == '0))) begin
        val = rf[ra];
        if (BYPASS) begin
          for (int p = 0; p < NWR; p++) begin
            if (wr_ok[p] && (wa[p] == ra)) val = wd[p];
          end
        end
      end
    end

    assign rd_dat[r*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_edubos5_rf_mp.sv
// Directed bench for edubos5_rf_mp: main 2R/2W bypass instance, a no-bypass instance
// and an instance without clear-on-reset, all sharing clock, reset and clr_req.
module tb_edubos5_rf_mp;

  logic clk;
  logic arst_n;
  logic clr_req;

  logic [1:0]  m_wr_en;
  logic [9:0]  m_wr_addr;
  logic [63:0] m_wr_dat;
  logic [9:0]  m_rd_addr;
  logic [63:0] m_rd_dat;
  logic        m_busy, m_conf;

  logic [0:0]  b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_dat;
  logic [4:0]  b_rd_addr;
  logic [31:0] b_rd_dat;
  logic        b_busy, b_conf;

  logic [0:0]  c_wr_en;
  logic [4:0]  c_wr_addr;
  logic [31:0] c_wr_dat;
  logic [4:0]  c_rd_addr;
  logic [31:0] c_rd_dat;
  logic        c_busy, c_conf;

  int total = 0;
  int bad   = 0;
  int n;

  edubos5_rf_mp #(.NRD(2), .NWR(2), .BYPASS(1'b1), .CLR_ON_RST(1'b1)) u_main (
    .clk(clk), .arst_n(arst_n), .clr_req(clr_req), .clr_busy(m_busy),
    .wr_en(m_wr_en), .wr_addr(m_wr_addr), .wr_dat(m_wr_dat),
    .rd_addr(m_rd_addr), .rd_dat(m_rd_dat), .wr_conflict(m_conf)
  );

  edubos5_rf_mp #(.NRD(1), .NWR(1), .BYPASS(1'b0), .CLR_ON_RST(1'b1)) u_nobyp (
    .clk(clk), .arst_n(arst_n), .clr_req(clr_req), .clr_busy(b_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_dat(b_wr_dat),
    .rd_addr(b_rd_addr), .rd_dat(b_rd_dat), .wr_conflict(b_conf)
  );

  edubos5_rf_mp #(.NRD(1), .NWR(1), .BYPASS(1'b1), .CLR_ON_RST(1'b0)) u_noclr (
    .clk(clk), .arst_n(arst_n), .clr_req(clr_req), .clr_busy(c_busy),
    .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_dat(c_wr_dat),
    .rd_addr(c_rd_addr), .rd_dat(c_rd_dat), .wr_conflict(c_conf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mwr(input int p, input logic [4:0] a, input logic [31:0] d);
    m_wr_en[p]            = 1'b1;
    m_wr_addr[p*5 +: 5]   = a;
    m_wr_dat[p*32 +: 32]  = d;
  endtask

  task automatic wr_off();
    m_wr_en = '0;
    b_wr_en = '0;
    c_wr_en = '0;
  endtask

  function automatic logic [31:0] mrd(input int r);
    return m_rd_dat[r*32 +: 32];
  endfunction

  // Counts clock edges until clr_busy falls, bounded
  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (m_busy && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0;
    arst_n = 1'b0;
    clr_req = 1'b0;
    m_wr_en = '0; m_wr_addr = '0; m_wr_dat = '0; m_rd_addr = '0;
    b_wr_en = '0; b_wr_addr = '0; b_wr_dat = '0; b_rd_addr = '0;
    c_wr_en = '0; c_wr_addr = '0; c_wr_dat = '0; c_rd_addr = '0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_main", 64'(m_busy), 64'd1);
    chk("rst_busy_nobyp", 64'(b_busy), 64'd1);
    chk("rst_busy_noclr", 64'(c_busy), 64'd0);
    chk("rst_conf_main", 64'(m_conf), 64'd0);
    chk("rst_conf_nobyp", 64'(b_conf), 64'd0);
    chk("rst_conf_noclr", 64'(c_conf), 64'd0);

    // T1: automatic clear after reset release
    @(negedge clk);
    arst_n = 1'b1;
    wait_clear(n);
    chk("t1_clear_len", 64'(n), 64'd32);
    chk("t1_nobyp_busy", 64'(b_busy), 64'd0);
    chk("t1_noclr_busy", 64'(c_busy), 64'd0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      m_rd_addr = {5'(31 - i), 5'(i)};
      b_rd_addr = 5'(i);
      #1;
      chk("t1_zero_p0", 64'(mrd(0)), 64'd0);
      chk("t1_zero_p1", 64'(mrd(1)), 64'd0);
      chk("t1_zero_nobyp", 64'(b_rd_dat), 64'd0);
    end

    // T2: bypass versus no bypass
    @(negedge clk);
    mwr(0, 5'd5, 32'hDEAD_BEEF);
    m_rd_addr = {5'd5, 5'd5};
    b_wr_en = 1'b1; b_wr_addr = 5'd5; b_wr_dat = 32'hDEAD_BEEF; b_rd_addr = 5'd5;
    c_wr_en = 1'b1; c_wr_addr = 5'd4; c_wr_dat = 32'h99; c_rd_addr = 5'd4;
    #1;
    chk("t2_bypass", 64'(mrd(0)), 64'hDEAD_BEEF);
    chk("t2_bypass_dup", 64'(mrd(1)), 64'hDEAD_BEEF);
    chk("t2_nobyp_old", 64'(b_rd_dat), 64'd0);
    chk("t2_noclr_bypass", 64'(c_rd_dat), 64'h99);
    @(negedge clk);
    wr_off();
    #1;
    chk("t2_nobyp_new", 64'(b_rd_dat), 64'hDEAD_BEEF);
    chk("t2_stored", 64'(mrd(0)), 64'hDEAD_BEEF);
    chk("t2_noclr_stored", 64'(c_rd_dat), 64'h99);

    // T3: x0 is hardwired
    @(negedge clk);
    mwr(0, 5'd0, 32'h1234);
    m_rd_addr = {5'd0, 5'd0};
    #1;
    chk("t3_x0_same", 64'(mrd(0)), 64'd0);
    @(posedge clk);
    #1;
    chk("t3_conf", 64'(m_conf), 64'd0);
    @(negedge clk);
    wr_off();
    #1;
    chk("t3_x0_after", 64'(mrd(1)), 64'd0);

    // T4: two ports to x7, higher port wins and conflict flags for one cycle
    @(negedge clk);
    mwr(0, 5'd7, 32'h1);
    mwr(1, 5'd7, 32'h2);
    m_rd_addr = {5'd7, 5'd7};
    #1;
    chk("t4_bypass_win", 64'(mrd(0)), 64'h2);
    chk("t4_conf_pre", 64'(m_conf), 64'd0);
    @(posedge clk);
    #1;
    chk("t4_conf", 64'(m_conf), 64'd1);
    @(negedge clk);
    wr_off();
    #1;
    chk("t4_x7", 64'(mrd(1)), 64'h2);
    @(posedge clk);
    #1;
    chk("t4_conf_drop", 64'(m_conf), 64'd0);

    // distinct addresses on both ports, then a few more registers
    @(negedge clk);
    mwr(0, 5'd8, 32'h11);
    mwr(1, 5'd9, 32'h22);
    m_rd_addr = {5'd9, 5'd8};
    #1;
    chk("t4b_byp_p0", 64'(mrd(0)), 64'h11);
    chk("t4b_byp_p1", 64'(mrd(1)), 64'h22);
    @(posedge clk);
    #1;
    chk("t4b_conf", 64'(m_conf), 64'd0);
    @(negedge clk);
    mwr(0, 5'd31, 32'hFFFF_FFFF);
    mwr(1, 5'd3, 32'h55);
    @(negedge clk);
    wr_off();
    m_rd_addr = {5'd3, 5'd31};
    #1;
    chk("t4b_x31", 64'(mrd(0)), 64'hFFFF_FFFF);
    chk("t4b_x3", 64'(mrd(1)), 64'h55);
    m_rd_addr = {5'd9, 5'd8};
    #1;
    chk("t4b_x8", 64'(mrd(0)), 64'h11);
    chk("t4b_x9", 64'(mrd(1)), 64'h22);

    // T5: clear on request, writes and a second request during clear are ignored
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    mwr(0, 5'd3, 32'hAA);
    mwr(1, 5'd3, 32'hBB);
    m_rd_addr = {5'd3, 5'd3};
    #1;
    chk("t5_busy", 64'(m_busy), 64'd1);
    chk("t5_rd_zero", 64'(mrd(0)), 64'd0);
    @(posedge clk);
    #1;
    chk("t5_conf_held", 64'(m_conf), 64'd0);
    clr_req = 1'b0;
    wr_off();
    wait_clear(n);
    chk("t5_clear_len", 64'(n + 1), 64'd32);
    @(negedge clk);
    m_rd_addr = {5'd31, 5'd3};
    #1;
    chk("t5_x3", 64'(mrd(0)), 64'd0);
    chk("t5_x31", 64'(mrd(1)), 64'd0);

    // T6: reset at clr_idx=10 restarts a full clear
    @(negedge clk);
    mwr(0, 5'd20, 32'h1234_5678);
    @(negedge clk);
    wr_off();
    m_rd_addr = {5'd20, 5'd20};
    #1;
    chk("t6_x20_pre", 64'(mrd(0)), 64'h1234_5678);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    #1;
    chk("t6_busy_rst", 64'(m_busy), 64'd1);
    chk("t6_noclr_busy_rst", 64'(c_busy), 64'd0);
    chk("t6_conf_rst", 64'(m_conf), 64'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    wait_clear(n);
    chk("t6_clear_len", 64'(n), 64'd32);
    chk("t6_noclr_idle", 64'(c_busy), 64'd0);
    @(negedge clk);
    #1;
    chk("t6_x20", 64'(mrd(0)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
